// File: rtl/c432_irq_sequencer.sv
// rtl/c432_irq_sequencer.sv - 27-channel banked interrupt request sequencer with valid/ready offer
module c432_irq_sequencer #(
    parameter int NCH     = 9,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH-1:0]     req_a,
    input  logic [NCH-1:0]     req_b,
    input  logic [NCH-1:0]     req_c,
    input  logic               mask_we,
    input  logic [3*NCH-1:0]   mask_wdata,
    input  logic               irq_ready,
    output logic               irq_valid,
    output logic [1:0]         irq_bank,
    output logic [3:0]         irq_chan,
    output logic [3*NCH-1:0]   pending,
    output logic [3*NCH-1:0]   mask,
    output logic               busy,
    output logic               timeout_err
);

    localparam int NB = 3 * NCH;
    // Counter value on the last OFFER cycle before auto-mask; unused when TIMEOUT is 0.
    localparam logic [7:0] LP_TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_valid;
    logic [1:0]      r_bank;
    logic [3:0]      r_chan;
    logic [NB-1:0]   r_grant;
    logic [7:0]      r_cnt;
    logic [NB-1:0]   r_pending;
    logic [NB-1:0]   r_mask;
    logic            r_err;

    state_t          w_state_nxt;
    logic            w_valid_nxt;
    logic [1:0]      w_bank_nxt;
    logic [3:0]      w_chan_nxt;
    logic [NB-1:0]   w_grant_nxt;
    logic [7:0]      w_cnt_nxt;
    logic [NB-1:0]   w_pending_nxt;
    logic [NB-1:0]   w_mask_nxt;
    logic            w_err_nxt;
    logic [NB-1:0]   w_clr;
    logic [NB-1:0]   w_automask;
    logic [NB-1:0]   w_req;
    logic [NB-1:0]   w_elig;
    logic            w_found;
    logic [1:0]      w_bank;
    logic [3:0]      w_chan;
    logic [NB-1:0]   w_grant;

    assign w_req  = {req_c, req_b, req_a};
    assign w_elig = r_pending & ~r_mask;

    // Priority winner: scan from lowest priority upward so the last hit is bank A, lowest channel.
    always_comb begin
        w_found = 1'b0;
        w_bank  = 2'd0;
        w_chan  = 4'd0;
        w_grant = '0;
        for (int b = 2; b >= 0; b--) begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (w_elig[b*NCH + i]) begin
                    w_found              = 1'b1;
                    w_bank               = 2'(b);
                    w_chan               = 4'(i);
                    w_grant              = '0;
                    w_grant[b*NCH + i]   = 1'b1;
                end
            end
        end
    end

    // Next-state and datapath updates; the offer registers only load on IDLE->OFFER so they stay frozen.
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_bank_nxt  = r_bank;
        w_chan_nxt  = r_chan;
        w_grant_nxt = r_grant;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_clr       = '0;
        w_automask  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_OFFER;
                    w_valid_nxt = 1'b1;
                    w_bank_nxt  = w_bank;
                    w_chan_nxt  = w_chan;
                    w_grant_nxt = w_grant;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_OFFER: begin
                if (r_valid && irq_ready) begin
                    w_clr       = r_grant;
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                end else if ((TIMEOUT != 0) && (r_cnt == LP_TO_LAST)) begin
                    w_automask  = r_grant;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                end else begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
        // A request arriving in the same cycle as its clear must survive.
        w_pending_nxt = (r_pending & ~w_clr) | w_req;
        // Auto-mask is merged into a concurrent software write rather than lost.
        w_mask_nxt    = (mask_we ? mask_wdata : r_mask) | w_automask;
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_bank    <= 2'd0;
            r_chan    <= 4'd0;
            r_grant   <= '0;
            r_cnt     <= 8'd0;
            r_pending <= '0;
            r_mask    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_valid   <= w_valid_nxt;
            r_bank    <= w_bank_nxt;
            r_chan    <= w_chan_nxt;
            r_grant   <= w_grant_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pending_nxt;
            r_mask    <= w_mask_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign irq_valid   = r_valid;
    assign irq_bank    = r_bank;
    assign irq_chan    = r_chan;
    assign pending     = r_pending;
    assign mask        = r_mask;
    assign busy        = (r_state != S_IDLE);
    assign timeout_err = r_err;

endmodule
